// File: rtl/stump_pkg.sv
// Shared encodings for the STUMP control unit: FSM states, opcodes and
// branch condition numbers.
package stump_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_INVALID = 2'b11
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SBC  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;

    localparam logic [3:0] CC_AL = 4'd0;
    localparam logic [3:0] CC_NV = 4'd1;
    localparam logic [3:0] CC_HI = 4'd2;
    localparam logic [3:0] CC_LS = 4'd3;
    localparam logic [3:0] CC_CC = 4'd4;
    localparam logic [3:0] CC_CS = 4'd5;
    localparam logic [3:0] CC_NE = 4'd6;
    localparam logic [3:0] CC_EQ = 4'd7;
    localparam logic [3:0] CC_VC = 4'd8;
    localparam logic [3:0] CC_VS = 4'd9;
    localparam logic [3:0] CC_PL = 4'd10;
    localparam logic [3:0] CC_MI = 4'd11;
    localparam logic [3:0] CC_GE = 4'd12;
    localparam logic [3:0] CC_LT = 4'd13;
    localparam logic [3:0] CC_GT = 4'd14;
    localparam logic [3:0] CC_LE = 4'd15;

endpackage

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator: decides whether a Bcc is taken given the
// registered condition codes {N,Z,V,C}.
module stump_cond_eval
    import stump_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       taken
);

    logic n, z, v, c;
    assign {n, z, v, c} = cc;

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_AL: taken = 1'b1;
            CC_NV: taken = 1'b0;
            CC_HI: taken = !c && !z;
            CC_LS: taken = c || z;
            CC_CC: taken = !c;
            CC_CS: taken = c;
            CC_NE: taken = !z;
            CC_EQ: taken = z;
            CC_VC: taken = !v;
            CC_VS: taken = v;
            CC_PL: taken = !n;
            CC_MI: taken = n;
            CC_GE: taken = (n == v);
            CC_LT: taken = (n != v);
            CC_GT: taken = !z && (n == v);
            CC_LE: taken = z || (n != v);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/stump_control.sv
// STUMP control unit: three-state FETCH/EXECUTE/MEMORY sequencer plus the
// condition-code register; every datapath enable is decoded combinationally.
module stump_control
    import stump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  flags_in,
    input  logic        mem_ready,
    output logic [1:0]  state,
    output logic [2:0]  alu_func,
    output logic        c_out,
    output logic [3:0]  cc,
    output logic        ir_en,
    output logic        pc_en,
    output logic        reg_wen,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic        addr_sel
);

    state_e     state_q, state_d;
    logic [3:0] cc_q, cc_d;
    logic [2:0] opcode;
    logic       s_bit;
    logic       taken;
    logic       unused_ir;

    assign opcode    = ir[15:13];
    assign s_bit     = ir[11];
    // The type bit and operand fields only matter to the datapath.
    assign unused_ir = ^{ir[12], ir[7:0]};

    stump_cond_eval u_cond (
        .cond  (ir[11:8]),
        .cc    (cc_q),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cc_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cc_d     = cc_q;
        alu_func = OP_ADD;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        reg_wen  = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        addr_sel = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_ren = 1'b1;
                ir_en   = mem_ready;
                pc_en   = mem_ready;
                if (mem_ready) state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (opcode)
                    OP_LDST: state_d = ST_MEMORY;
                    OP_BCC: begin
                        pc_en   = taken;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        alu_func = opcode;
                        reg_wen  = 1'b1;
                        if (s_bit) cc_d = flags_in;
                        state_d  = ST_FETCH;
                    end
                endcase
            end
            ST_MEMORY: begin
                addr_sel = 1'b1;
                // ir[11] is the load/store select in a transfer instruction.
                if (s_bit) begin
                    mem_wen = 1'b1;
                end else begin
                    mem_ren = 1'b1;
                    reg_wen = mem_ready;
                end
                if (mem_ready) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign state = state_q;
    assign cc    = cc_q;
    assign c_out = cc_q[0];

endmodule

// File: tb/tb_stump_control.sv
// Self-checking bench for stump_control: condition table, directed corner
// sequences and a randomized run against a cycle-level reference model.
module tb_stump_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  flags_in;
    logic        mem_ready;
    logic [1:0]  state;
    logic [2:0]  alu_func;
    logic        c_out;
    logic [3:0]  cc;
    logic        ir_en, pc_en, reg_wen, mem_ren, mem_wen, addr_sel;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0=fetch, 1=execute, 2=memory.
    int       m_st = 0;
    logic [3:0] m_cc = 4'b0000;

    stump_control dut (
        .clk(clk), .rst(rst), .ir(ir), .flags_in(flags_in), .mem_ready(mem_ready),
        .state(state), .alu_func(alu_func), .c_out(c_out), .cc(cc),
        .ir_en(ir_en), .pc_en(pc_en), .reg_wen(reg_wen), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .addr_sel(addr_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp_taken;
    } cond_vec_t;

    function automatic logic cond_true(input logic [3:0] cd, input logic [3:0] c);
        logic n, z, v, cy, base;
        n = c[3]; z = c[2]; v = c[1]; cy = c[0];
        case (cd[3:1])
            3'd0: base = 1'b1;
            3'd1: base = !cy && !z;
            3'd2: base = !cy;
            3'd3: base = !z;
            3'd4: base = !v;
            3'd5: base = !n;
            3'd6: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ cd[0];
    endfunction

    // Packed as {state, alu_func, c_out, cc, ir_en, pc_en, reg_wen, mem_ren, mem_wen, addr_sel}
    function automatic logic [15:0] model_out(input logic [15:0] i, input logic m);
        logic [1:0] st; logic [2:0] alu; logic ie, pe, rw, mr, mw, as;
        st = m_st[1:0]; alu = 3'd0; ie = 0; pe = 0; rw = 0; mr = 0; mw = 0; as = 0;
        if (m_st == 0) begin
            mr = 1; ie = m; pe = m;
        end else if (m_st == 1) begin
            if (i[15:13] < 3'd6) begin alu = i[15:13]; rw = 1; end
            else if (i[15:13] == 3'd7) pe = cond_true(i[11:8], m_cc);
        end else begin
            as = 1;
            if (i[11]) mw = 1;
            else begin mr = 1; rw = m; end
        end
        return {st, alu, m_cc[0], m_cc, ie, pe, rw, mr, mw, as};
    endfunction

    function automatic void model_step(input logic r, input logic [15:0] i,
                                       input logic [3:0] f, input logic m);
        if (r) begin
            m_st = 0; m_cc = 4'b0000;
        end else if (m_st == 0) begin
            if (m) m_st = 1;
        end else if (m_st == 1) begin
            if (i[15:13] < 3'd6 && i[11]) m_cc = f;
            m_st = (i[15:13] == 3'd6) ? 2 : 0;
        end else if (m) begin
            m_st = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, compare all outputs mid-cycle, then clock the model.
    task automatic apply(input logic r, input logic [15:0] i, input logic [3:0] f, input logic m);
        rst = r; ir = i; flags_in = f; mem_ready = m;
        @(negedge clk);
        chk("outputs", {state, alu_func, c_out, cc, ir_en, pc_en, reg_wen, mem_ren, mem_wen, addr_sel},
            model_out(i, m));
        @(posedge clk); #1;
        model_step(r, i, f, m);
    endtask

    cond_vec_t tbl[14];

    initial begin
        tbl[0]  = '{4'b0000, 4'd0,  1'b1};
        tbl[1]  = '{4'b0000, 4'd1,  1'b0};
        tbl[2]  = '{4'b0000, 4'd2,  1'b1};
        tbl[3]  = '{4'b0001, 4'd3,  1'b1};
        tbl[4]  = '{4'b0100, 4'd7,  1'b1};
        tbl[5]  = '{4'b0100, 4'd6,  1'b0};
        tbl[6]  = '{4'b1000, 4'd12, 1'b0};
        tbl[7]  = '{4'b1010, 4'd12, 1'b1};
        tbl[8]  = '{4'b1000, 4'd13, 1'b1};
        tbl[9]  = '{4'b0000, 4'd14, 1'b1};
        tbl[10] = '{4'b0100, 4'd15, 1'b1};
        tbl[11] = '{4'b0010, 4'd9,  1'b1};
        tbl[12] = '{4'b1000, 4'd10, 1'b0};
        tbl[13] = '{4'b0001, 4'd4,  1'b0};

        rst = 1; ir = 16'h0800; flags_in = 4'b1001; mem_ready = 1;
        @(posedge clk); #1;
        model_step(1'b1, ir, flags_in, mem_ready);

        // Reset state, then ADD S=1 updates cc.
        apply(1, 16'h0800, 4'b1001, 1);
        chk("rst_state", {14'd0, state}, 16'd0);
        chk("rst_c_out", {15'd0, c_out}, 16'd0);
        chk("rst_enables", {12'd0, mem_ren, addr_sel, mem_wen, reg_wen}, 16'b1000);
        apply(0, 16'h0800, 4'b1001, 1);
        chk("add_exec_state", {14'd0, state}, 16'd1);
        apply(0, 16'h0800, 4'b1001, 1);
        chk("add_back_fetch", {14'd0, state}, 16'd0);
        chk("add_cc", {12'd0, cc}, 16'h9);
        chk("add_c_out", {15'd0, c_out}, 16'd1);

        // Fetch stall for three cycles.
        for (int k = 0; k < 3; k++) begin
            apply(0, 16'hC800, 4'b0000, 0);
            chk("fetch_stall_state", {14'd0, state}, 16'd0);
        end
        apply(0, 16'hC800, 4'b0000, 1);

        // Store with two wait cycles in MEMORY.
        apply(0, 16'hC800, 4'b0000, 1);
        chk("store_mem_state", {14'd0, state}, 16'd2);
        apply(0, 16'hC800, 4'b0000, 0);
        apply(0, 16'hC800, 4'b0000, 0);
        chk("store_wait_wen", {14'd0, mem_wen, addr_sel}, 16'b11);
        apply(0, 16'hC800, 4'b0000, 1);
        chk("store_done_state", {14'd0, state}, 16'd0);

        // BEQ / BNE with Z set.
        apply(0, 16'h0800, 4'b0100, 1);
        apply(0, 16'h0800, 4'b0100, 1);
        apply(0, 16'hE700, 4'b0000, 1);
        chk("beq_pc_en", {15'd0, pc_en}, 16'd1);
        ir = 16'hE600; #1;
        chk("bne_pc_en", {15'd0, pc_en}, 16'd0);
        apply(0, 16'hE600, 4'b1111, 1);
        chk("branch_cc_kept", {12'd0, cc}, 16'h4);

        // ADD S=0 leaves cc; reset aborts a load.
        apply(0, 16'h0000, 4'b1111, 1);
        apply(0, 16'h0000, 4'b1111, 1);
        chk("add_s0_cc", {12'd0, cc}, 16'h4);
        apply(0, 16'hC000, 4'b0000, 1);
        apply(0, 16'hC000, 4'b0000, 1);
        apply(1, 16'hC000, 4'b0000, 0);
        chk("rst_load_state", {14'd0, state}, 16'd0);
        chk("rst_load_cc", {12'd0, cc}, 16'h0);

        // Reset abandons a store.
        apply(0, 16'hC800, 4'b0000, 1);
        apply(0, 16'hC800, 4'b0000, 1);
        apply(1, 16'hC800, 4'b0000, 0);
        chk("rst_store_wen", {15'd0, mem_wen}, 16'd0);

        // Condition table.
        foreach (tbl[k]) begin
            apply(1, 16'h0000, 4'b0000, 1);
            apply(0, 16'h0800, tbl[k].flags, 1);
            apply(0, 16'h0800, tbl[k].flags, 1);
            apply(0, {3'b111, 1'b0, tbl[k].cond, 8'h00}, 4'b0000, 1);
            chk("cond_table", {15'd0, pc_en}, {15'd0, tbl[k].exp_taken});
            apply(0, {3'b111, 1'b0, tbl[k].cond, 8'h00}, 4'b0000, 1);
        end

        // Randomized run against the model.
        for (int k = 0; k < 600; k++) begin
            apply(($urandom_range(31) == 0), 16'($urandom), 4'($urandom),
                  ($urandom_range(3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stump_control.md
STUMP_CONTROL -- requirements
Module: stump_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk in, rst in.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: ir  input  16  current instruction register contents, held by the datapath.
REQ-005 Port: flags_in  input  4  ALU flags {N,Z,V,C} for the instruction in EXECUTE.
REQ-006 Port: mem_ready  input  1  memory handshake; the access completes in the cycle it is 1.
REQ-007 Port: state  output  2  FETCH=00, EXECUTE=01, MEMORY=10.
REQ-008 Port: alu_func  output  3  function code to the ALU.
REQ-009 Port: c_out  output  1  carry into the ALU, equal to registered C.
REQ-010 Port: cc  output  4  registered condition codes {N,Z,V,C}.
REQ-011 Ports: ir_en, pc_en, reg_wen, mem_ren, mem_wen, addr_sel  output  1 each; ir load, PC write, register-file write, memory read, memory write, memory address source (0=PC, 1=ALU result latch).

Function
REQ-012 Decode: ir[15:13]=opcode; ir[12]=type; ir[11]=S (ALU ops), L/S (0=load, 1=store, opcode 110), or cond[3] (opcode 111); ir[11:8]=branch condition.
REQ-013 FETCH: mem_ren=1, addr_sel=0; ir_en=pc_en=mem_ready; stay in FETCH while mem_ready=0; go to EXECUTE when mem_ready=1.
REQ-014 EXECUTE, opcode 000-101: alu_func=opcode, reg_wen=1; cc <= flags_in at the edge if S=1; next FETCH.
REQ-015 EXECUTE, opcode 110: alu_func=000 (address add), reg_wen=0, cc unchanged; next MEMORY.
REQ-016 EXECUTE, opcode 111: alu_func=000 (PC+offset); pc_en=1 if and only if the condition is true on registered cc; cc unchanged; next FETCH.
REQ-017 Conditions 0-15: AL, NV, HI(!C&!Z), LS(C|Z), CC(!C), CS(C), NE(!Z), EQ(Z), VC(!V), VS(V), PL(!N), MI(N), GE(N==V), LT(N!=V), GT(!Z&(N==V)), LE(Z|(N!=V)).
REQ-018 MEMORY: addr_sel=1; load: mem_ren=1, reg_wen=mem_ready; store: mem_wen=1; stay in MEMORY while mem_ready=0; go to FETCH when mem_ready=1.
REQ-019 Any output not named for a state SHALL be 0 in that state; alu_func SHALL be 000 in FETCH and MEMORY.
REQ-020 Outputs SHALL be combinational from state, ir, cc and mem_ready; state and cc SHALL be the only registers.
REQ-021 Unreachable state 11 SHALL drive all enables to 0 and go to FETCH on the next edge.
REQ-022 cc SHALL change only at an EXECUTE edge with an ALU opcode and S=1; a branch never updates cc.

Reset
REQ-023 rst=1 at a clock edge SHALL set state=FETCH and cc=0000, overriding every other transition.
REQ-024 After reset: c_out=0, mem_ren=1, addr_sel=0, mem_wen=0, reg_wen=0.
REQ-025 Reset while in MEMORY with a store SHALL abandon the access; mem_wen=0 from the following cycle.

Structure
REQ-026 Package stump_pkg SHALL hold the state encoding, opcode constants (ADD..BCC), and the condition-code constants 0-15.
REQ-027 Condition evaluation SHALL be the single combinational sub-module stump_cond_eval (inputs: cond[3:0], cc[3:0]; output: taken).

Verification
REQ-028 Reset, then mem_ready=1 constantly with ir=ADD S=1, and flags_in=1001 -> states FETCH, EXECUTE, FETCH; cc=1001 after EXECUTE; c_out=1.
REQ-029 FETCH with mem_ready held 0 for 3 cycles -> state stays FETCH, ir_en=0 for 3 cycles, then ir_en=pc_en=1 for 1 cycle.
REQ-030 Store (ir[15:11]=11001) with mem_ready=0 for 2 MEMORY cycles -> mem_wen=1, addr_sel=1 for 3 cycles, then FETCH.
REQ-031 cc=0100 (Z): BEQ (cond 0111) -> pc_en=1; BNE (cond 0110) -> pc_en=0; cc stays 0100.
REQ-032 ADD with S=0 and flags_in=1111 -> cc unchanged; rst during MEMORY load -> FETCH and cc=0000 at the next edge.
